// File: rtl/rng_fill_ctrl_if.sv
// AXI master and soft-register bundle used by the RNG fill controller.
interface rng_fill_ctrl_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ID_W   = 16
);
  // AXI write address
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic                awvalid;
  logic                awready;
  // AXI write data
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // AXI write response
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  // AXI read channels (idle)
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  // Soft-register port
  logic                softreg_req_valid;
  logic                softreg_req_isWrite;
  logic [31:0]         softreg_req_addr;
  logic [63:0]         softreg_req_data;
  logic                softreg_resp_valid;
  logic [63:0]         softreg_resp_data;

  modport master (
    output awid, awaddr, awlen, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    input  softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
    output softreg_resp_valid, softreg_resp_data
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    output softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
    input  softreg_resp_valid, softreg_resp_data
  );
endinterface

// File: rtl/rng_fill_ctrl.sv
// Fills a memory region with xorshift64-derived data via AXI write bursts,
// programmed and monitored through soft registers.
module rng_fill_ctrl #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned ID_W      = 16,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  rng_fill_ctrl_if.master bus
);
  localparam int unsigned LANE_W  = 64;
  localparam int unsigned LANES   = DATA_W / LANE_W;
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

  localparam logic [31:0] REG_BASE  = 32'h00;
  localparam logic [31:0] REG_LINES = 32'h08;
  localparam logic [31:0] REG_SEED  = 32'h10;
  localparam logic [31:0] REG_CTRL  = 32'h18;

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [31:0]         lines_q, lines_d;
  logic [63:0]         seed_q, seed_d;
  logic [63:0]         s_q, s_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [31:0]         remaining_q, remaining_d;
  logic [31:0]         lines_done_q, lines_done_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [BURST_W-1:0]  burst_n_q, burst_n_d;
  logic [BURST_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic                awvalid_q, awvalid_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [7:0]          awlen_q, awlen_d;
  logic                wvalid_q, wvalid_d;
  logic                wlast_q, wlast_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                bready_q, bready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [63:0]         resp_data_q, resp_data_d;

  logic                sr_wr_c, sr_rd_c;
  logic [63:0]         status_c;
  logic                unused_c;

  function automatic logic [63:0] xorshift64(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  function automatic logic [DATA_W-1:0] lanes_of(input logic [63:0] s);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      d[i*LANE_W +: LANE_W] = s + 64'(i);
    end
    return d;
  endfunction

  // Beats in the next burst: capped by MAX_BURST, remaining lines and the 4 KB page end.
  function automatic logic [BURST_W-1:0] burst_len(input logic [ADDR_W-1:0] addr,
                                                   input logic [31:0]       rem);
    logic [6:0]  to_4k;
    logic [31:0] n;
    to_4k = 7'd64 - 7'(addr[11:6]);
    n     = 32'(MAX_BURST);
    if (rem < n) n = rem;
    if (32'(to_4k) < n) n = 32'(to_4k);
    return BURST_W'(n);
  endfunction

  assign sr_wr_c  = bus.softreg_req_valid & bus.softreg_req_isWrite;
  assign sr_rd_c  = bus.softreg_req_valid & ~bus.softreg_req_isWrite;
  assign status_c = {lines_done_q, 29'd0, err_q, done_q, (state_q != ST_IDLE)};

  // Read-side response ID/data are never consumed.
  assign unused_c = ^{bus.bid, bus.arready, bus.rid, bus.rdata, bus.rresp, bus.rlast, bus.rvalid};

  // Next-state, job bookkeeping and registered-output values.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    lines_d      = lines_q;
    seed_d       = seed_q;
    s_d          = s_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    lines_done_d = lines_done_q;
    done_d       = done_q;
    err_d        = err_q;
    burst_n_d    = burst_n_q;
    beat_cnt_d   = beat_cnt_q;
    awaddr_d     = '0;
    awlen_d      = '0;
    wdata_d      = '0;
    wlast_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;

    if (sr_rd_c) begin
      resp_valid_d = 1'b1;
      resp_data_d  = (bus.softreg_req_addr == REG_CTRL) ? status_c : 64'd0;
    end

    case (state_q)
      ST_IDLE: begin
        if (sr_wr_c) begin
          case (bus.softreg_req_addr)
            REG_BASE: begin
              base_d      = ADDR_W'(bus.softreg_req_data);
              base_d[5:0] = 6'd0;
            end
            REG_LINES: lines_d = bus.softreg_req_data[31:0];
            REG_SEED:  seed_d  = (bus.softreg_req_data == 64'd0) ? 64'd1 : bus.softreg_req_data;
            REG_CTRL: begin
              done_d       = 1'b0;
              err_d        = 1'b0;
              lines_done_d = '0;
              s_d          = seed_q;
              cur_addr_d   = base_q;
              remaining_d  = lines_q;
              if (lines_q == 32'd0) done_d  = 1'b1;
              else                  state_d = ST_AW;
            end
            default: ;
          endcase
        end
      end
      ST_AW: begin
        if (awvalid_q && bus.awready) begin
          state_d    = ST_W;
          beat_cnt_d = '0;
        end
      end
      ST_W: begin
        if (wvalid_q && bus.wready) begin
          s_d        = xorshift64(s_q);
          beat_cnt_d = beat_cnt_q + BURST_W'(1);
          if (wlast_q) state_d = ST_B;
        end
      end
      ST_B: begin
        if (bready_q && bus.bvalid) begin
          if (bus.bresp != 2'd0) err_d = 1'b1;
          lines_done_d = lines_done_q + 32'(burst_n_q);
          cur_addr_d   = cur_addr_q + (ADDR_W'(burst_n_q) << 6);
          remaining_d  = remaining_q - 32'(burst_n_q);
          if (remaining_d == 32'd0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_AW;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they are valid on the same edge.
    awvalid_d = (state_d == ST_AW);
    wvalid_d  = (state_d == ST_W);
    bready_d  = (state_d == ST_B);
    if (state_d == ST_AW) begin
      burst_n_d = burst_len(cur_addr_d, remaining_d);
      awaddr_d  = cur_addr_d;
      awlen_d   = 8'(burst_n_d) - 8'd1;
    end
    if (state_d == ST_W) begin
      wdata_d = lanes_of(s_d);
      wlast_d = (beat_cnt_d == (burst_n_d - BURST_W'(1)));
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      lines_q      <= '0;
      seed_q       <= 64'd1;
      s_q          <= 64'd1;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      lines_done_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      burst_n_q    <= '0;
      beat_cnt_q   <= '0;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      wdata_q      <= '0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      lines_q      <= lines_d;
      seed_q       <= seed_d;
      s_q          <= s_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      lines_done_q <= lines_done_d;
      done_q       <= done_d;
      err_q        <= err_d;
      burst_n_q    <= burst_n_d;
      beat_cnt_q   <= beat_cnt_d;
      awvalid_q    <= awvalid_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      wvalid_q     <= wvalid_d;
      wlast_q      <= wlast_d;
      wdata_q      <= wdata_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.awid               = ID_W'(0);
  assign bus.awaddr             = awaddr_q;
  assign bus.awlen              = awlen_q;
  assign bus.awsize             = 3'd6;
  assign bus.awvalid            = awvalid_q;
  assign bus.wdata              = wdata_q;
  assign bus.wstrb              = '1;
  assign bus.wlast              = wlast_q;
  assign bus.wvalid             = wvalid_q;
  assign bus.bready             = bready_q;
  assign bus.arid               = ID_W'(0);
  assign bus.araddr             = ADDR_W'(0);
  assign bus.arlen              = 8'd0;
  assign bus.arsize             = 3'd0;
  assign bus.arvalid            = 1'b0;
  assign bus.rready             = 1'b1;
  assign bus.softreg_resp_valid = resp_valid_q;
  assign bus.softreg_resp_data  = resp_data_q;

endmodule

// File: tb/tb_rng_fill_ctrl.sv
// Scoreboard bench for rng_fill_ctrl: a job-level model predicts bursts, beat data
// and status; an AXI slave/monitor process pops and compares as the DUT presents them.
module tb_rng_fill_ctrl;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned ID_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rng_fill_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  rng_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_BURST(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
  } aw_t;

  aw_t          exp_aw[$];
  logic [512:0] exp_w[$];
  logic [63:0]  exp_rd[$];

  int errors = 0;
  int checks = 0;
  int job_id = 0;
  int err_idx = -1;
  bit stall = 1'b0;
  int b_done = 0;
  int w_beats = 0;

  task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: got %s expected none", name, what);
  endtask

  function automatic logic [63:0] xs64(input logic [63:0] x);
    logic [63:0] v;
    v = x;
    v = v ^ (v << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

  // Job model: split the region into page-respecting bursts and list every beat.
  task automatic build_model(input logic [63:0] base, input logic [31:0] lines,
                             input logic [63:0] seed, input int eidx,
                             output int nb, output logic [63:0] status);
    logic [63:0]  addr, rem, n, to4k, s;
    logic [511:0] beat;
    logic         err;
    addr = base & ~64'd63;
    rem  = 64'(lines);
    s    = (seed == 64'd0) ? 64'd1 : seed;
    nb   = 0;
    err  = 1'b0;
    while (rem != 64'd0) begin
      to4k = (64'd4096 - (addr & 64'hFFF)) >> 6;
      n = 64'd16;
      if (rem < n) n = rem;
      if (to4k < n) n = to4k;
      exp_aw.push_back('{addr: addr, len: 8'(n - 64'd1)});
      for (int b = 0; b < int'(n); b++) begin
        for (int i = 0; i < 8; i++) beat[i*64 +: 64] = s + 64'(i);
        exp_w.push_back({(b == int'(n) - 1), beat});
        s = xs64(s);
      end
      if (nb == eidx) err = 1'b1;
      addr = addr + (n << 6);
      rem  = rem - n;
      nb++;
    end
    status = {lines, 29'd0, err, 1'b1, 1'b0};
  endtask

  task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    bus.softreg_req_valid   = 1'b1;
    bus.softreg_req_isWrite = 1'b1;
    bus.softreg_req_addr    = a;
    bus.softreg_req_data    = d;
    @(negedge clk);
    bus.softreg_req_valid   = 1'b0;
    bus.softreg_req_isWrite = 1'b0;
  endtask

  task automatic sr_read(input logic [31:0] a, input logic [63:0] e);
    @(negedge clk);
    bus.softreg_req_valid   = 1'b1;
    bus.softreg_req_isWrite = 1'b0;
    bus.softreg_req_addr    = a;
    exp_rd.push_back(e);
    @(negedge clk);
    bus.softreg_req_valid   = 1'b0;
  endtask

  // Start at cycle t, status read at t+1.
  task automatic start_and_read(input logic [63:0] e);
    @(negedge clk);
    bus.softreg_req_valid   = 1'b1;
    bus.softreg_req_isWrite = 1'b1;
    bus.softreg_req_addr    = 32'h18;
    bus.softreg_req_data    = 64'd0;
    @(negedge clk);
    bus.softreg_req_isWrite = 1'b0;
    exp_rd.push_back(e);
    @(negedge clk);
    bus.softreg_req_valid   = 1'b0;
  endtask

  task automatic run_job(input logic [63:0] base, input logic [31:0] lines, input logic [63:0] seed,
                         input int eidx, input bit stl, input bit poke, input bit prog);
    int nb;
    int t;
    logic [63:0] st;
    if (prog) begin
      sr_write(32'h00, base);
      sr_write(32'h08, 64'(lines));
      sr_write(32'h10, seed);
    end
    err_idx = eidx;
    stall   = stl;
    job_id++;
    build_model(base, lines, seed, eidx, nb, st);
    start_and_read((lines == 32'd0) ? 64'h2 : 64'h1);
    if (poke) begin
      sr_write(32'h00, 64'hDEAD_0000);
      sr_write(32'h08, 64'd5);
      sr_write(32'h18, 64'd0);
    end
    t = 0;
    while (b_done < nb && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) fail("job_timeout", "no completion");
    repeat (2) @(negedge clk);
    sr_read(32'h18, st);
    repeat (2) @(negedge clk);
    chk("aw_drained", 576'(exp_aw.size()), 576'(0));
    chk("w_drained", 576'(exp_w.size()), 576'(0));
  endtask

  task automatic reset_mid_burst();
    int nb;
    int t;
    logic [63:0] st;
    sr_write(32'h00, 64'h8000);
    sr_write(32'h08, 64'd32);
    sr_write(32'h10, 64'h1234);
    err_idx = -1;
    stall   = 1'b1;
    job_id++;
    build_model(64'h8000, 32'd32, 64'h1234, -1, nb, st);
    sr_write(32'h18, 64'd0);
    t = 0;
    while (!(w_beats > 0 && bus.wvalid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) fail("reset_wait_timeout", "no W beat");
    rst_n = 1'b0;
    #1;
    chk("rst_awvalid", 576'(bus.awvalid), 576'(0));
    chk("rst_wvalid", 576'(bus.wvalid), 576'(0));
    chk("rst_wlast", 576'(bus.wlast), 576'(0));
    chk("rst_wdata", 576'(bus.wdata), 576'(0));
    chk("rst_bready", 576'(bus.bready), 576'(0));
    chk("rst_awaddr", 576'(bus.awaddr), 576'(0));
    chk("rst_resp", 576'({bus.softreg_resp_valid, bus.softreg_resp_data}), 576'(0));
    exp_aw.delete();
    exp_w.delete();
    exp_rd.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // AXI slave + scoreboard monitor, all decisions at the falling edge.
  initial begin : slave_mon
    bit aw_pend, w_pend, b_hs, b_armed, spur;
    int b_delay, b_idx, seen_job;
    logic [71:0]  aw_h;
    logic [512:0] w_h;
    aw_t e;
    aw_pend = 0; w_pend = 0; b_hs = 0; b_armed = 0; spur = 0;
    b_delay = 0; b_idx = 0; seen_job = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_pend = 0; w_pend = 0; b_hs = 0; b_armed = 0; spur = 0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'd0;
        continue;
      end
      if (job_id != seen_job) begin
        seen_job = job_id;
        b_idx = 0;
        b_done = 0;
        w_beats = 0;
      end
      if (bus.softreg_resp_valid) begin
        if (exp_rd.size() == 0) fail("rd_unexpected", "response");
        else chk("softreg_rd", 576'(bus.softreg_resp_data), 576'(exp_rd.pop_front()));
      end
      if (spur) begin
        bus.bvalid = 1'b0;
        bus.bresp  = 2'd0;
        spur = 0;
      end
      if (b_hs) begin
        bus.bvalid = 1'b0;
        bus.bresp  = 2'd0;
        b_hs = 0;
        b_idx++;
        b_done++;
      end
      bus.awready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (aw_pend) begin
        chk("awvalid_hold", 576'(bus.awvalid), 576'(1));
        chk("aw_stable", 576'({bus.awaddr, bus.awlen}), 576'(aw_h));
      end
      if (w_pend) begin
        chk("wvalid_hold", 576'(bus.wvalid), 576'(1));
        chk("w_stable", 576'({bus.wlast, bus.wdata}), 576'(w_h));
      end
      aw_pend = bus.awvalid && !bus.awready;
      aw_h    = {bus.awaddr, bus.awlen};
      w_pend  = bus.wvalid && !bus.wready;
      w_h     = {bus.wlast, bus.wdata};
      if (bus.awvalid && bus.awready) begin
        if (exp_aw.size() == 0) fail("aw_unexpected", "AW handshake");
        else begin
          e = exp_aw.pop_front();
          chk("aw_addr", 576'(bus.awaddr), 576'(e.addr));
          chk("aw_len", 576'(bus.awlen), 576'(e.len));
        end
        chk("aw_size_id", 576'({bus.awsize, bus.awid}), 576'({3'd6, 16'd0}));
      end
      if (bus.wvalid && bus.wready) begin
        w_beats++;
        if (exp_w.size() == 0) fail("w_unexpected", "W beat");
        else chk("w_beat", 576'({bus.wlast, bus.wdata}), 576'(exp_w.pop_front()));
        if (bus.wlast) begin
          b_armed = 1;
          b_delay = stall ? int'($urandom_range(0, 4)) : 0;
        end
      end
      if (b_armed) begin
        if (b_delay == 0) begin
          bus.bvalid = 1'b1;
          bus.bresp  = (b_idx == err_idx) ? 2'd2 : 2'd0;
          b_armed = 0;
        end else begin
          b_delay--;
        end
      end else if (stall && !bus.bvalid && !bus.bready && $urandom_range(0, 7) == 0) begin
        bus.bvalid = 1'b1;
        bus.bresp  = 2'd2;
        spur = 1;
      end
      if (bus.bvalid && !spur && bus.bready) b_hs = 1;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish expected completion before time limit");
    $fatal(1);
  end

  initial begin : stim
    logic [63:0] rb, rs;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bid     = '0;
    bus.bresp   = 2'd0;
    bus.bvalid  = 1'b0;
    bus.arready = 1'b0;
    bus.rid     = '0;
    bus.rdata   = '0;
    bus.rresp   = 2'd0;
    bus.rlast   = 1'b0;
    bus.rvalid  = 1'b0;
    bus.softreg_req_valid   = 1'b0;
    bus.softreg_req_isWrite = 1'b0;
    bus.softreg_req_addr    = '0;
    bus.softreg_req_data    = '0;

    repeat (3) @(negedge clk);
    chk("reset_valids", 576'({bus.awvalid, bus.wvalid, bus.bready, bus.softreg_resp_valid}), 576'(0));
    chk("reset_resp_data", 576'(bus.softreg_resp_data), 576'(0));
    chk("read_idle", 576'({bus.arvalid, bus.rready}), 576'({1'b0, 1'b1}));
    rst_n = 1'b1;
    sr_read(32'h18, 64'd0);
    sr_read(32'h00, 64'd0);

    run_job(64'h1000, 32'd4, 64'd5, -1, 1'b0, 1'b0, 1'b1);
    run_job(64'h0FC0, 32'd20, 64'h9E37_79B9_7F4A_7C15, -1, 1'b0, 1'b0, 1'b1);
    rb = {$urandom(), $urandom()} & ~64'd63;
    rs = {$urandom(), $urandom()};
    run_job(rb, 32'd37, rs, -1, 1'b1, 1'b0, 1'b1);
    run_job(64'h0, 32'd40, 64'd77, 1, 1'b1, 1'b0, 1'b1);
    run_job(64'h2000, 32'd0, 64'd7, -1, 1'b0, 1'b0, 1'b1);
    run_job(64'h3000, 32'd1, 64'd0, -1, 1'b0, 1'b0, 1'b1);
    run_job(64'h5000, 32'd40, 64'd9, -1, 1'b1, 1'b1, 1'b1);
    run_job(64'h5000, 32'd40, 64'd9, -1, 1'b0, 1'b0, 1'b0);
    run_job(64'hFFFF_FFFF_FFFF_FF00, 32'd8, 64'd3, -1, 1'b0, 1'b0, 1'b1);

    reset_mid_burst();
    sr_read(32'h18, 64'd0);
    run_job(64'h7FC0, 32'd6, 64'd11, -1, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 4; k++) begin
      rb = {$urandom(), $urandom()} & ~64'd63;
      rs = {$urandom(), $urandom()};
      run_job(rb, 32'($urandom_range(1, 50)), rs, int'($urandom_range(0, 3)) - 1,
              1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
